// File: rtl/comparator_seq_ctrl_pkg.sv
// Shared constants and FSM encoding for the sequential slice-wise magnitude comparator.
package comparator_seq_ctrl_pkg;

    localparam int WIDTH_DEF = 256;
    localparam int SLICE_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comparator_seq_ctrl_slice_cmp.sv
// Shared combinational slice comparator: the 16-bit data-flow block, or a generic
// parameterised equivalent when the slice is not 16 bits wide.
module comparator_16bit_d (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        greater_o,
    output logic        less_o,
    output logic        equal_o
);
    assign greater_o = (a_i > b_i);
    assign less_o    = (a_i < b_i);
    assign equal_o   = (a_i == b_i);
endmodule

module comparator_seq_ctrl_slice_cmp #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    output logic             greater_o,
    output logic             less_o,
    output logic             equal_o
);
    if (SLICE == 16) begin : g_cmp16
        comparator_16bit_d u_cmp (
            .a_i       (a_i),
            .b_i       (b_i),
            .greater_o (greater_o),
            .less_o    (less_o),
            .equal_o   (equal_o)
        );
    end else begin : g_cmp_generic
        assign greater_o = (a_i > b_i);
        assign less_o    = (a_i < b_i);
        assign equal_o   = (a_i == b_i);
    end
endmodule

// File: rtl/comparator_seq_ctrl.sv
// Wide unsigned magnitude comparator that walks operands MSB slice first through one
// shared slice comparator, stopping at the first unequal slice.
//
// state   | meaning
// IDLE    | waiting for start; previous result held
// RUN     | comparing slice idx; busy high
// DONE    | one-cycle done pulse, result valid
module comparator_seq_ctrl
    import comparator_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             less,
    output logic             equal
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             greater_q, greater_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;

    logic [SLICE-1:0] a_sl, b_sl;
    logic             sl_gt, sl_lt, sl_eq;

    assign a_sl = a_q[idx_q*SLICE +: SLICE];
    assign b_sl = b_q[idx_q*SLICE +: SLICE];

    comparator_seq_ctrl_slice_cmp #(
        .SLICE (SLICE)
    ) u_slice_cmp (
        .a_i       (a_sl),
        .b_i       (b_sl),
        .greater_o (sl_gt),
        .less_o    (sl_lt),
        .equal_o   (sl_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            greater_q <= greater_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        greater_d = greater_q;
        less_d    = less_q;
        equal_d   = equal_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    idx_d     = IDXW'(NSLICE - 1);
                    greater_d = 1'b0;
                    less_d    = 1'b0;
                    equal_d   = 1'b0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sl_gt) begin
                    greater_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (sl_lt) begin
                    less_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (sl_eq && (idx_q == '0)) begin
                    equal_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    assign greater = greater_q;
    assign less    = less_q;
    assign equal   = equal_q;

endmodule
